// File: rtl/pipe_pkg.sv
// Shared types for the generic pipeline stage register.
// The FSM state encoding doubles as the entry count held by a skid stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_t;

  // Wide all-zero control word; each stage slices off its own CTRL_W bits.
  localparam logic [255:0] CTRL_NOP = '0;

endpackage

// File: rtl/pipe_entry.sv
// One storage slot holding a packed control+data bundle plus its valid flag.
// Priority is reset, then load, then clear_valid; the payload is kept when the slot is cleared.
module pipe_entry #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] d_i,
  output logic         valid_o,
  output logic [W-1:0] q_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = d_i;
    end else if (clear_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign q_o     = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline stage register with stall back-pressure and synchronous flush.
// SKID=1 builds a 2-entry skid buffer with a registered in_ready; SKID=0 a single combinational-ready entry.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 208,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o
);

  localparam int W = CTRL_W + DATA_W;

  logic [W-1:0] in_bundle;
  logic [W-1:0] main_d;
  logic [W-1:0] main_q;
  logic         main_load;
  logic         main_clear;
  logic         main_valid;
  logic         push;
  logic         pop;

  assign in_bundle = {in_ctrl_i, in_data_i};
  // An offer coinciding with flush is dropped even when the stage looks ready.
  assign push      = in_valid_i & in_ready_o & ~flush_i;
  assign pop       = main_valid & out_ready_i;

  pipe_entry #(.W(W)) u_main (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (main_load),
    .clear_i (main_clear),
    .d_i     (main_d),
    .valid_o (main_valid),
    .q_o     (main_q)
  );

  generate
    if (SKID) begin : g_skid
      pipe_state_t  state_q, state_d;
      logic         in_ready_q, in_ready_d;
      logic         skid_load, skid_clear, skid_valid, sel_skid;
      logic [W-1:0] skid_q;

      pipe_entry #(.W(W)) u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .d_i     (in_bundle),
        .valid_o (skid_valid),
        .q_o     (skid_q)
      );

      always_comb begin
        state_d    = state_q;
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        sel_skid   = 1'b0;
        if (flush_i) begin
          state_d    = ST_EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end else begin
          case (state_q)
            ST_EMPTY: begin
              if (push) begin
                main_load = 1'b1;
                state_d   = ST_ONE;
              end
            end
            ST_ONE: begin
              if (push && pop) begin
                main_load = 1'b1;
              end else if (push) begin
                skid_load = 1'b1;
                state_d   = ST_FULL;
              end else if (pop) begin
                main_clear = 1'b1;
                state_d    = ST_EMPTY;
              end
            end
            ST_FULL: begin
              if (pop) begin
                main_load  = 1'b1;
                sel_skid   = 1'b1;
                skid_clear = 1'b1;
                state_d    = ST_ONE;
              end
            end
            default: state_d = ST_EMPTY;
          endcase
        end
        in_ready_d = (state_d != ST_FULL);
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          state_q    <= ST_EMPTY;
          in_ready_q <= 1'b1;
        end else begin
          state_q    <= state_d;
          in_ready_q <= in_ready_d;
        end
      end

      assign main_d      = sel_skid ? skid_q : in_bundle;
      assign in_ready_o  = in_ready_q;
      assign occupancy_o = {1'b0, main_valid} + {1'b0, skid_valid};
    end else begin : g_single
      // Accepting while the held entry leaves replaces it without a bubble.
      assign in_ready_o  = ~main_valid | out_ready_i;
      assign main_load   = push;
      assign main_clear  = flush_i | (pop & ~push);
      assign main_d      = in_bundle;
      assign occupancy_o = {1'b0, main_valid};
    end
  endgenerate

  assign out_valid_o = main_valid;
  assign out_ctrl_o  = main_valid ? main_q[W-1:DATA_W] : CTRL_NOP[CTRL_W-1:0];
  assign out_data_o  = main_q[DATA_W-1:0];

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomized checks of pipe_stage_skid, SKID=1 and SKID=0 instances.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_pipe_stage_skid;

  localparam int CW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          inV = 1'b0, outR = 1'b0;
  logic [CW-1:0] inC = '0;
  logic [DW-1:0] inD = '0;
  logic          inRdy, outV;
  logic [CW-1:0] outC;
  logic [DW-1:0] outD;
  logic [1:0]    occ;

  logic          inV0 = 1'b0, outR0 = 1'b0;
  logic [CW-1:0] inC0 = '0;
  logic [DW-1:0] inD0 = '0;
  logic          inRdy0, outV0;
  logic [CW-1:0] outC0;
  logic [DW-1:0] outD0;
  logic [1:0]    occ0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(inV), .in_ready_o(inRdy), .in_ctrl_i(inC), .in_data_i(inD),
    .out_valid_o(outV), .out_ready_i(outR), .out_ctrl_o(outC), .out_data_o(outD),
    .occupancy_o(occ)
  );

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .flush_i(1'b0),
    .in_valid_i(inV0), .in_ready_o(inRdy0), .in_ctrl_i(inC0), .in_data_i(inD0),
    .out_valid_o(outV0), .out_ready_i(outR0), .out_ctrl_o(outC0), .out_data_o(outD0),
    .occupancy_o(occ0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [23:0] mq[$];
  int          seq;
  logic        acc, pop;

  initial begin
    // Reset with a full-ones offer present
    rst = 1'b1; inV = 1'b1; inC = 8'hFF; inD = 16'hAAAA; outR = 1'b1;
    inV0 = 1'b1; inC0 = 8'hFF; inD0 = 16'hAAAA;
    tick(); tick();
    chk("rst_outV", 32'(outV), 0);
    chk("rst_outC", 32'(outC), 0);
    chk("rst_outD", 32'(outD), 0);
    chk("rst_occ", 32'(occ), 0);
    chk("rst_inRdy", 32'(inRdy), 1);
    chk("rst0_outV", 32'(outV0), 0);
    chk("rst0_occ", 32'(occ0), 0);
    rst = 1'b0; inV = 1'b0; inV0 = 1'b0;
    tick();
    chk("post_rst_inRdy", 32'(inRdy), 1);
    chk("post_rst_outV", 32'(outV), 0);

    // Streaming 1..10 with downstream always ready
    outR = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      inV = 1'b1; inC = 8'h01; inD = 16'(i);
      tick();
      chk("stream_outV", 32'(outV), 1);
      chk("stream_outD", 32'(outD), 32'(i));
      chk("stream_inRdy", 32'(inRdy), 1);
    end
    inV = 1'b0;
    tick();
    chk("stream_drain_outV", 32'(outV), 0);
    chk("stream_drain_outC", 32'(outC), 0);
    chk("stream_drain_occ", 32'(occ), 0);

    // Stall with A, B, C
    inV = 1'b1; inC = 8'h11; inD = 16'h00A1;
    tick();
    chk("stall_A_outD", 32'(outD), 32'h00A1);
    outR = 1'b0; inC = 8'h12; inD = 16'h00B2;
    tick();
    chk("stall_occ2", 32'(occ), 2);
    chk("stall_inRdy0", 32'(inRdy), 0);
    chk("stall_A_held", 32'(outD), 32'h00A1);
    inC = 8'h13; inD = 16'h00C3;
    tick();
    chk("stall_C_refused_occ", 32'(occ), 2);
    chk("stall_A_still", 32'(outD), 32'h00A1);
    chk("stall_A_ctrl", 32'(outC), 32'h11);
    outR = 1'b1;
    tick();
    chk("release_B", 32'(outD), 32'h00B2);
    chk("release_B_occ", 32'(occ), 1);
    tick();
    chk("release_C", 32'(outD), 32'h00C3);
    chk("release_C_ctrl", 32'(outC), 32'h13);
    inV = 1'b0;
    tick();
    chk("release_empty", 32'(outV), 0);

    // Flush while FULL with D offered
    inV = 1'b1; inC = 8'h21; inD = 16'h0A0A;
    tick();
    outR = 1'b0; inC = 8'h22; inD = 16'h0B0B;
    tick();
    chk("flfull_occ", 32'(occ), 2);
    flush = 1'b1; inC = 8'h24; inD = 16'h0D0D;
    tick();
    chk("flfull_outV", 32'(outV), 0);
    chk("flfull_outC", 32'(outC), 0);
    chk("flfull_occ0", 32'(occ), 0);
    chk("flfull_inRdy", 32'(inRdy), 1);
    flush = 1'b0; inV = 1'b0; outR = 1'b1;
    tick();
    chk("flfull_D_dropped", 32'(outV), 0);

    // Flush in ONE with an offer while ready
    inV = 1'b1; inC = 8'h31; inD = 16'h0031;
    tick();
    flush = 1'b1; inC = 8'h32; inD = 16'h0032;
    tick();
    chk("flone_outV", 32'(outV), 0);
    chk("flone_occ", 32'(occ), 0);
    flush = 1'b0; inV = 1'b0;
    tick();
    chk("flone_dropped", 32'(outV), 0);

    // Simultaneous in/out in ONE, SKID=1
    inV = 1'b1; inC = 8'h41; inD = 16'h0X41 & 16'h0F41;
    inD = 16'h0441;
    tick();
    chk("sim_X", 32'(outD), 32'h0441);
    inC = 8'h42; inD = 16'h0442;
    tick();
    chk("sim_Y", 32'(outD), 32'h0442);
    chk("sim_occ", 32'(occ), 1);
    inV = 1'b0;
    tick();
    chk("sim_drain", 32'(occ), 0);

    // SKID=0: replacement and combinational ready
    outR0 = 1'b1; inV0 = 1'b1; inC0 = 8'h51; inD0 = 16'h0551;
    tick();
    chk("s0_X_outV", 32'(outV0), 1);
    chk("s0_X", 32'(outD0), 32'h0551);
    inC0 = 8'h52; inD0 = 16'h0552;
    #1;
    chk("s0_rdy_pass", 32'(inRdy0), 1);
    tick();
    chk("s0_Y", 32'(outD0), 32'h0552);
    chk("s0_occ", 32'(occ0), 1);
    outR0 = 1'b0; inC0 = 8'h53; inD0 = 16'h0553;
    #1;
    chk("s0_rdy_stall", 32'(inRdy0), 0);
    tick();
    chk("s0_Y_held", 32'(outD0), 32'h0552);
    outR0 = 1'b1;
    #1;
    chk("s0_rdy_release", 32'(inRdy0), 1);
    tick();
    chk("s0_Z", 32'(outD0), 32'h0553);
    inV0 = 1'b0;
    tick();
    chk("s0_empty_outV", 32'(outV0), 0);
    chk("s0_empty_outC", 32'(outC0), 0);
    chk("s0_empty_occ", 32'(occ0), 0);

    // Random traffic against a reference FIFO
    seq = 1; inV = 1'b0; mq.delete();
    for (int c = 0; c < 400; c++) begin
      flush = ($urandom_range(99) < 5);
      rst   = ($urandom_range(99) == 0);
      outR  = 1'($urandom_range(1));
      if (!inV && $urandom_range(1) == 1) begin
        inV = 1'b1; inC = {1'b1, 7'(seq)}; inD = 16'(seq); seq++;
      end
      acc = inV && (mq.size() < 2) && !flush && !rst;
      pop = (mq.size() > 0) && outR;
      tick();
      if (rst || flush) mq.delete();
      else begin
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back({inC, inD});
      end
      if (acc) inV = 1'b0;
      chk("rnd_occ", 32'(occ), 32'(mq.size()));
      chk("rnd_outV", 32'(outV), 32'(mq.size() > 0));
      chk("rnd_inRdy", 32'(inRdy), 32'(mq.size() < 2));
      if (mq.size() > 0) chk("rnd_bundle", 32'({outC, outD}), 32'(mq[0]));
      else               chk("rnd_nop_ctrl", 32'(outC), 0);
    end
    rst = 1'b0; flush = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
